audio_i2s_transmitter: RTL and testbench

Consumer end of the audio sample FIFO: pops mixed mono samples written by the audio mixer and serializes them to the codec DAC as I2S. The block generates bit clock and LR clock as master, duplicates each sample to both channels and flags underflow when the FIFO runs dry. It sits between the audio output FIFO and the codec pins.

---
 rtl/audio_i2s_transmitter.sv | 196 +++++++++++++++++++
 tb/tb_audio_i2s_transmitter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_i2s_transmitter.sv
// I2S master transmitter: pops mono samples from the audio FIFO
// and plays each one on both channels, flagging FIFO underflow.
//
// Ports:
//   clk, reset        system clock, async active-high reset
//   en                playback enable, sampled at frame boundaries
//   fifo_empty        FIFO empty flag
//   fifo_rd_data      FIFO data, valid the clk after fifo_rd_en
//   fifo_rd_en        one-clk registered pop strobe
//   aud_bclk          I2S bit clock (master)
//   aud_daclrck       LR clock, 0 = left, 1 = right
//   aud_dacdat        serial data, MSB first
//   underflow         one-clk pulse when a frame loads without a sample
//   underflow_count   saturating underflow event count
module audio_i2s_transmitter #(
  parameter int DATA_WIDTH = 16,
  parameter int BCLK_DIV   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  aud_bclk,
  output logic                  aud_daclrck,
  output logic                  aud_dacdat,
  output logic                  underflow,
  output logic [15:0]           underflow_count
);

  localparam int W  = DATA_WIDTH;
  localparam int SW = 2 * W;
  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BW = $clog2(SW);

  typedef enum logic [1:0] {
    F_EMPTY,
    F_REQ,
    F_WAIT,
    F_FULL
  } fstate_t;

  typedef enum logic [1:0] {
    STOP,
    RUN,
    DRAIN
  } frstate_t;

  fstate_t         fs_q;
  frstate_t        fr_q;
  logic            rd_en_q;
  logic [W-1:0]    hold_q;
  logic [SW-1:0]   shift_q;
  logic [DW-1:0]   div_cnt_q;
  logic [BW-1:0]   bit_cnt_q;
  logic [BW-1:0]   bit_cnt_d;
  logic            bclk_q;
  logic            lrck_q;
  logic            dat_q;
  logic            uf_q;
  logic [15:0]     ucnt_q;
  logic [15:0]     ucnt_d;

  logic full;
  logic tick;
  logic fall;
  logic wrap;
  logic load;
  logic uf_set;

  assign full = (fs_q == F_FULL);
  assign tick = (div_cnt_q == DW'(BCLK_DIV - 1));
  assign fall = (fr_q != STOP) && tick && bclk_q;
  assign wrap = fall && (fr_q == RUN) &&
                (bit_cnt_q == BW'(SW - 1));

  // A load takes the hold register either when playback starts
  // from STOP or at a frame wrap while playback stays enabled.
  assign load = full && en &&
                ((fr_q == STOP) || wrap);

  // Frame wrap with playback on but nothing held: play silence.
  assign uf_set = wrap && en && !full;

  assign bit_cnt_d = bit_cnt_q + 1'b1;
  assign ucnt_d = (ucnt_q == 16'hFFFF) ? ucnt_q
                                       : ucnt_q + 16'd1;

  // Fetch FSM: keeps a single prefetched sample in hold_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fs_q    <= F_EMPTY;
      rd_en_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      rd_en_q <= 1'b0;
      unique case (fs_q)
        F_EMPTY: begin
          if (!fifo_empty) begin
            fs_q    <= F_REQ;
            rd_en_q <= 1'b1;
          end
        end
        F_REQ: begin
          fs_q <= F_WAIT;
        end
        F_WAIT: begin
          fs_q   <= F_FULL;
          hold_q <= fifo_rd_data;
        end
        F_FULL: begin
          if (load) fs_q <= F_EMPTY;
        end
      endcase
    end
  end

  // Frame FSM: bit clock divider, LR clock and data shifter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fr_q      <= STOP;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      bclk_q    <= 1'b0;
      lrck_q    <= 1'b0;
      dat_q     <= 1'b0;
      uf_q      <= 1'b0;
    end else begin
      uf_q <= uf_set;
      unique case (fr_q)
        STOP: begin
          div_cnt_q <= '0;
          bit_cnt_q <= '0;
          bclk_q    <= 1'b0;
          lrck_q    <= 1'b0;
          dat_q     <= 1'b0;
          if (load) begin
            shift_q <= {hold_q, hold_q};
            fr_q    <= RUN;
          end
        end
        RUN, DRAIN: begin
          div_cnt_q <= tick ? '0 : div_cnt_q + 1'b1;
          if (tick) bclk_q <= ~bclk_q;
          if (fall) begin
            if (fr_q == DRAIN) begin
              fr_q      <= STOP;
              bit_cnt_q <= '0;
              lrck_q    <= 1'b0;
              dat_q     <= 1'b0;
            end else if (!wrap) begin
              bit_cnt_q <= bit_cnt_d;
              dat_q     <= shift_q[SW-1];
              shift_q   <= shift_q << 1;
              lrck_q    <= (bit_cnt_d >= BW'(W));
            end else begin
              // Right LSB goes out together with the LRCK edge.
              bit_cnt_q <= '0;
              lrck_q    <= 1'b0;
              dat_q     <= shift_q[SW-1];
              if (!en) begin
                shift_q <= '0;
                fr_q    <= DRAIN;
              end else if (full) begin
                shift_q <= {hold_q, hold_q};
              end else begin
                shift_q <= '0;
              end
            end
          end
        end
        default: begin
          fr_q <= STOP;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ucnt_q <= '0;
    end else if (uf_set) begin
      ucnt_q <= ucnt_d;
    end
  end

  assign fifo_rd_en      = rd_en_q;
  assign aud_bclk        = bclk_q;
  assign aud_daclrck     = lrck_q;
  assign aud_dacdat      = dat_q;
  assign underflow       = uf_q;
  assign underflow_count = ucnt_q;

endmodule

// File: tb/tb_audio_i2s_transmitter.sv
// Bench for audio_i2s_transmitter: FIFO model, I2S receiver
// and a word scoreboard filled as samples are pushed.
module tb_audio_i2s_transmitter;

  localparam int BDIV = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [15:0] fifo_rd_data = '0;
  logic        fifo_rd_en;
  logic        aud_bclk;
  logic        aud_daclrck;
  logic        aud_dacdat;
  logic        underflow;
  logic [15:0] underflow_count;

  audio_i2s_transmitter #(
    .DATA_WIDTH(16),
    .BCLK_DIV  (BDIV)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .en             (en),
    .fifo_empty     (fifo_empty),
    .fifo_rd_data   (fifo_rd_data),
    .fifo_rd_en     (fifo_rd_en),
    .aud_bclk       (aud_bclk),
    .aud_daclrck    (aud_daclrck),
    .aud_dacdat     (aud_dacdat),
    .underflow      (underflow),
    .underflow_count(underflow_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [15:0] fq[$];
  logic [15:0] sb[$];

  int n_rd = 0;
  int n_uf = 0;
  int n_rise = 0;
  int ndec = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] s);
    fq.push_back(s);
    sb.push_back(s);
    sb.push_back(s);
  endtask

  task automatic expect_silence(input int frames);
    for (int i = 0; i < 2 * frames; i++) sb.push_back(16'h0000);
  endtask

  task automatic clr_counts();
    n_rd = 0;
    n_uf = 0;
    n_rise = 0;
    ndec = 0;
  endtask

  task automatic outs_zero(input string p);
    check({p, "_bclk"}, 32'(aud_bclk), 32'd0);
    check({p, "_lrck"}, 32'(aud_daclrck), 32'd0);
    check({p, "_dat"}, 32'(aud_dacdat), 32'd0);
    check({p, "_rden"}, 32'(fifo_rd_en), 32'd0);
    check({p, "_uf"}, 32'(underflow), 32'd0);
    check({p, "_ucnt"}, 32'(underflow_count), 32'd0);
  endtask

  task automatic wait_run();
    int t = 0;
    while (!aud_bclk && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!aud_bclk) check("tmo_run", 32'(aud_bclk), 32'd1);
  endtask

  task automatic wait_words(input int n);
    int t = 0;
    while (ndec < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (ndec < n) check("tmo_words", ndec, n);
  endtask

  task automatic wait_idle();
    int t = 0;
    int low = 0;
    while (low < 40 && t < 3000) begin
      @(negedge clk);
      low = aud_bclk ? 0 : low + 1;
      t++;
    end
    if (low < 40) check("tmo_idle", low, 40);
  endtask

  // FIFO model: registered empty flag, data one clk after pop.
  initial begin
    forever begin
      @(posedge clk);
      if (fifo_rd_en && fq.size() > 0)
        fifo_rd_data <= fq.pop_front();
      fifo_empty <= (fq.size() == 0);
    end
  end

  // I2S receiver: bits taken on bclk rise, word closes when
  // LRCK changes (that bit is the LSB of the closing slot).
  initial begin
    logic        p_bclk;
    logic        p_dat;
    logic        p_lrck;
    logic        lr_prev;
    logic        chan_exp;
    logic [15:0] sr;
    int          bitn;
    int          low;
    p_bclk = 0;
    p_dat = 0;
    p_lrck = 0;
    lr_prev = 0;
    chan_exp = 0;
    sr = '0;
    bitn = -1;
    low = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        p_bclk = 0;
        p_dat = 0;
        p_lrck = 0;
        lr_prev = 0;
        chan_exp = 0;
        bitn = -1;
        low = 0;
      end else begin
        if (fifo_rd_en) n_rd++;
        if (underflow) n_uf++;
        if (aud_dacdat != p_dat || aud_daclrck != p_lrck)
          check("chg_at_fall", {30'd0, p_bclk, aud_bclk}, 32'd2);
        if (aud_bclk && !p_bclk) begin
          n_rise++;
          bitn++;
          sr = {sr[14:0], aud_dacdat};
          if (aud_daclrck != lr_prev) begin
            check("slot_len", bitn, 16);
            check("slot_chan", 32'(lr_prev), 32'(chan_exp));
            chan_exp = !chan_exp;
            if (sb.size() == 0)
              check("sb_avail", sb.size(), 1);
            else
              check("word", 32'(sr), 32'(sb.pop_front()));
            ndec++;
            bitn = 0;
            lr_prev = aud_daclrck;
          end
        end
        low = aud_bclk ? 0 : low + 1;
        if (low > 2 * BDIV) begin
          bitn = -1;
          chan_exp = 0;
          lr_prev = 0;
        end
        p_bclk = aud_bclk;
        p_dat = aud_dacdat;
        p_lrck = aud_daclrck;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    outs_zero("rst");
    reset = 0;
    @(negedge clk);

    // single sample, stopped after one frame
    clr_counts();
    push(16'hA5C3);
    en = 1;
    wait_run();
    en = 0;
    wait_words(2);
    wait_idle();
    check("s_rd", n_rd, 1);
    check("s_uf", n_uf, 0);
    check("s_rise", n_rise, 33);
    check("s_sb", sb.size(), 0);

    // continuous stream of three samples
    clr_counts();
    push(16'h8000);
    push(16'h7FFF);
    push(16'h0001);
    en = 1;
    wait_words(4);
    en = 0;
    wait_words(6);
    wait_idle();
    check("c_rd", n_rd, 3);
    check("c_uf", n_uf, 0);
    check("c_rise", n_rise, 97);
    check("c_sb", sb.size(), 0);

    // underflow, then a late sample plays in the next frame
    clr_counts();
    push(16'h1234);
    expect_silence(1);
    en = 1;
    wait_words(2);
    push(16'hBEEF);
    wait_words(4);
    en = 0;
    wait_words(6);
    wait_idle();
    check("u_rd", n_rd, 2);
    check("u_uf", n_uf, 1);
    check("u_cnt", 32'(underflow_count), 32'd1);
    check("u_sb", sb.size(), 0);

    // stop mid-frame with a sample prefetched
    clr_counts();
    fq.push_back(16'h0F0F);
    fq.push_back(16'hF0F0);
    sb.push_back(16'h0F0F);
    sb.push_back(16'h0F0F);
    en = 1;
    wait_run();
    en = 0;
    wait_words(2);
    wait_idle();
    repeat (50) @(negedge clk);
    check("p_rd", n_rd, 2);
    check("p_uf", n_uf, 0);
    check("p_rise", n_rise, 33);
    check("p_bclk", 32'(aud_bclk), 32'd0);
    check("p_cnt", 32'(underflow_count), 32'd1);

    // re-enable: the held sample plays first
    clr_counts();
    sb.push_back(16'hF0F0);
    sb.push_back(16'hF0F0);
    en = 1;
    wait_run();
    en = 0;
    wait_words(2);
    wait_idle();
    check("r_rd", n_rd, 0);
    check("r_uf", n_uf, 0);
    check("r_sb", sb.size(), 0);

    // saturation of the underflow counter
    force dut.ucnt_q = 16'hFFFE;
    #1;
    release dut.ucnt_q;
    @(negedge clk);
    check("sat_pre", 32'(underflow_count), 32'hFFFE);
    clr_counts();
    push(16'h5555);
    expect_silence(3);
    en = 1;
    wait_words(6);
    en = 0;
    wait_words(8);
    wait_idle();
    check("sat_uf", n_uf, 3);
    check("sat_cnt", 32'(underflow_count), 32'hFFFF);
    check("sat_sb", sb.size(), 0);

    // async reset mid-frame, in-flight read dropped
    fq.push_back(16'h1111);
    fq.push_back(16'h2222);
    en = 1;
    wait_run();
    #2;
    reset = 1;
    #1;
    outs_zero("amid");
    @(negedge clk);
    @(negedge clk);
    sb.delete();
    reset = 0;
    clr_counts();
    repeat (60) @(negedge clk);
    check("ar_rise", n_rise, 0);
    check("ar_rd", n_rd, 0);
    check("ar_bclk", 32'(aud_bclk), 32'd0);
    en = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
